// File: rtl/btn_stepper.sv
`default_nettype none
// ============================================================================
// btn_stepper : debounced pushbuttons -> gated step commands and colour select
// Revision    : 1.0
// ============================================================================
module btn_stepper #(
   parameter int         DB_CYCLES  = 1000000,
   parameter int         STEP_DIV   = 2500000,
   parameter int         REPEAT_DLY = 8,
   parameter logic [3:0] COLOR_INIT = 4'd1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btnU,
   input  logic       btnD,
   input  logic       btnL,
   input  logic       btnR,
   input  logic       btnC,
   input  logic       upBlock,
   input  logic       downBlock,
   input  logic       leftBlock,
   input  logic       rightBlock,
   output logic       btnClk,
   output logic [3:0] btns,
   output logic [3:0] player_color,
   output logic       blocked
);

   localparam int DB_W   = $clog2(DB_CYCLES + 1);
   localparam int DIV_W  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam int HOLD_W = $clog2(REPEAT_DLY + 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_HOLD   = 2'd1;
   localparam logic [1:0] S_REPEAT = 2'd2;

   // Bit order {U, D, R, L, C} makes bits [4:1] equal to the btns encoding.
   logic [4:0] w_raw;
   logic [4:0] r_sync1;
   logic [4:0] r_sync2;
   logic [4:0] w_db;

   assign w_raw = {btnU, btnD, btnR, btnL, btnC};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= w_raw;
         r_sync2 <= r_sync1;
      end
   end

   generate
      for (genvar i = 0; i < 5; i++) begin : g_db
         logic [DB_W-1:0] r_cnt;
         logic            r_lvl;

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               r_cnt <= '0;
               r_lvl <= 1'b0;
            end else if (r_sync2[i] != r_lvl) begin
               if (r_cnt == DB_W'(DB_CYCLES - 1)) begin
                  r_lvl <= r_sync2[i];
                  r_cnt <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end else begin
               r_cnt <= '0;
            end
         end

         assign w_db[i] = r_lvl;
      end
   endgenerate

   logic [DIV_W-1:0] r_div;
   logic             w_div_end;
   logic             w_step;

   assign w_div_end = (r_div == DIV_W'(STEP_DIV - 1));
   assign w_step    = w_div_end & btnClk;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_div  <= '0;
         btnClk <= 1'b0;
      end else if (w_div_end) begin
         r_div  <= '0;
         btnClk <= ~btnClk;
      end else begin
         r_div  <= r_div + 1'b1;
      end
   end

   logic [3:0] w_dir;
   logic       w_valid;
   logic [3:0] w_d;
   logic       w_d_blocked;

   assign w_dir       = w_db[4:1];
   assign w_valid     = (w_dir != 4'd0) && ((w_dir & (w_dir - 4'd1)) == 4'd0);
   assign w_d         = w_valid ? w_dir : 4'd0;
   assign w_d_blocked = |(w_d & {upBlock, downBlock, rightBlock, leftBlock});

   logic [1:0]        r_state;
   logic [1:0]        w_state_nxt;
   logic [3:0]        r_latch;
   logic [3:0]        w_latch_nxt;
   logic [HOLD_W-1:0] r_hold;
   logic [HOLD_W-1:0] w_hold_nxt;
   logic [3:0]        w_btns_nxt;
   logic              w_blocked_nxt;
   logic              w_hold_done;

   assign w_hold_done = (r_hold == HOLD_W'(REPEAT_DLY - 1));

   // Everything the FSM owns advances only on the btnClk falling edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_latch <= 4'd0;
         r_hold  <= '0;
         btns    <= 4'd0;
         blocked <= 1'b0;
      end else if (w_step) begin
         r_state <= w_state_nxt;
         r_latch <= w_latch_nxt;
         r_hold  <= w_hold_nxt;
         btns    <= w_btns_nxt;
         blocked <= w_blocked_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (w_valid && !w_d_blocked) w_state_nxt = S_HOLD;
         S_HOLD: begin
            if (w_d != r_latch)   w_state_nxt = S_IDLE;
            else if (w_hold_done) w_state_nxt = S_REPEAT;
         end
         S_REPEAT: if (w_d != r_latch) w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_btns_nxt    = 4'd0;
      w_blocked_nxt = 1'b0;
      w_latch_nxt   = r_latch;
      w_hold_nxt    = r_hold;
      case (r_state)
         S_IDLE: begin
            if (w_valid && !w_d_blocked) begin
               w_btns_nxt  = w_d;
               w_latch_nxt = w_d;
               w_hold_nxt  = '0;
            end else if (w_valid) begin
               w_blocked_nxt = 1'b1;
            end
         end
         S_HOLD: begin
            if ((w_d == r_latch) && !w_hold_done) w_hold_nxt = r_hold + 1'b1;
         end
         S_REPEAT: begin
            if (w_d == r_latch) begin
               if (w_d_blocked) w_blocked_nxt = 1'b1;
               else             w_btns_nxt    = w_d;
            end
         end
         default: ;
      endcase
   end

   logic r_c_prev;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_c_prev     <= 1'b0;
         player_color <= COLOR_INIT;
      end else begin
         r_c_prev <= w_db[0];
         if (w_db[0] && !r_c_prev) player_color <= player_color + 4'd1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_btn_stepper.sv
`default_nettype none
// ============================================================================
// tb_btn_stepper : boundary-by-boundary vector table plus directed corner cases
// Revision       : 1.0
// ============================================================================
module tb_btn_stepper;

   logic       clk = 1'b0;
   logic       rst;
   logic       btnU, btnD, btnL, btnR, btnC;
   logic       upBlock, downBlock, leftBlock, rightBlock;
   logic       btnClk;
   logic [3:0] btns;
   logic [3:0] player_color;
   logic       blocked;

   int n_cmp = 0;
   int n_err = 0;

   btn_stepper #(
      .DB_CYCLES (4),
      .STEP_DIV  (2),
      .REPEAT_DLY(3),
      .COLOR_INIT(4'd1)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .btnU        (btnU),
      .btnD        (btnD),
      .btnL        (btnL),
      .btnR        (btnR),
      .btnC        (btnC),
      .upBlock     (upBlock),
      .downBlock   (downBlock),
      .leftBlock   (leftBlock),
      .rightBlock  (rightBlock),
      .btnClk      (btnClk),
      .btns        (btns),
      .player_color(player_color),
      .blocked     (blocked)
   );

   always #5 clk = ~clk;

   // One record per step boundary: inputs driven just after the previous
   // boundary, outputs expected just after this one. dir/blk use the btns
   // encoding {U, D, R, L}.
   typedef struct {
      logic [3:0] dir;
      logic [3:0] blk;
      logic [3:0] exp_btns;
      logic       exp_blocked;
   } vec_t;

   vec_t vecs[64];
   int   nv = 0;

   task automatic add_vec(input logic [3:0] d, input logic [3:0] b,
                          input logic [3:0] e, input logic bl);
      vecs[nv].dir         = d;
      vecs[nv].blk         = b;
      vecs[nv].exp_btns    = e;
      vecs[nv].exp_blocked = bl;
      nv++;
   endtask

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic drive_dir(input logic [3:0] d);
      {btnU, btnD, btnR, btnL} = d;
   endtask

   task automatic drive_blk(input logic [3:0] b);
      {upBlock, downBlock, rightBlock, leftBlock} = b;
   endtask

   // Returns at the falling clk edge right after the next btnClk 1->0.
   task automatic step_bnd();
      logic prev;
      int   n;
      prev = btnClk;
      n    = 0;
      while (1) begin
         @(negedge clk);
         if (prev && !btnClk) break;
         prev = btnClk;
         n++;
         if (n > 16) begin
            n_cmp++;
            n_err++;
            $display("FAIL step_bnd: got no btnClk fall in %0d cycles, expected one within 4", n);
            break;
         end
      end
   endtask

   initial begin
      logic exp_clk[8];

      exp_clk = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

      // Single step then auto-repeat on R, released
      add_vec(4'd2, 4'd0, 4'd0, 1'b0);
      add_vec(4'd2, 4'd0, 4'd2, 1'b0);
      add_vec(4'd2, 4'd0, 4'd0, 1'b0);
      add_vec(4'd2, 4'd0, 4'd0, 1'b0);
      add_vec(4'd2, 4'd0, 4'd0, 1'b0);
      for (int i = 0; i < 5; i++) add_vec(4'd2, 4'd0, 4'd2, 1'b0);
      add_vec(4'd0, 4'd0, 4'd2, 1'b0);
      add_vec(4'd0, 4'd0, 4'd0, 1'b0);
      add_vec(4'd0, 4'd0, 4'd0, 1'b0);
      // U gated by upBlock, then released
      add_vec(4'd8, 4'd8, 4'd0, 1'b0);
      add_vec(4'd8, 4'd8, 4'd0, 1'b1);
      add_vec(4'd8, 4'd8, 4'd0, 1'b1);
      add_vec(4'd8, 4'd0, 4'd8, 1'b0);
      add_vec(4'd0, 4'd0, 4'd0, 1'b0);
      add_vec(4'd0, 4'd0, 4'd0, 1'b0);
      add_vec(4'd0, 4'd0, 4'd0, 1'b0);
      // U+D together: no direction
      add_vec(4'd12, 4'd0, 4'd0, 1'b0);
      add_vec(4'd12, 4'd0, 4'd0, 1'b0);
      add_vec(4'd12, 4'd0, 4'd0, 1'b0);
      add_vec(4'd0, 4'd0, 4'd0, 1'b0);
      add_vec(4'd0, 4'd0, 4'd0, 1'b0);
      // R then switch to L during HOLD: one dead boundary before L issues
      add_vec(4'd2, 4'd0, 4'd0, 1'b0);
      add_vec(4'd2, 4'd0, 4'd2, 1'b0);
      add_vec(4'd1, 4'd0, 4'd0, 1'b0);
      add_vec(4'd1, 4'd0, 4'd0, 1'b0);
      add_vec(4'd1, 4'd0, 4'd1, 1'b0);
      add_vec(4'd0, 4'd0, 4'd0, 1'b0);
      add_vec(4'd0, 4'd0, 4'd0, 1'b0);
      // D into REPEAT, blocked inside REPEAT, unblocked
      add_vec(4'd4, 4'd0, 4'd0, 1'b0);
      add_vec(4'd4, 4'd0, 4'd4, 1'b0);
      add_vec(4'd4, 4'd0, 4'd0, 1'b0);
      add_vec(4'd4, 4'd0, 4'd0, 1'b0);
      add_vec(4'd4, 4'd0, 4'd0, 1'b0);
      add_vec(4'd4, 4'd0, 4'd4, 1'b0);
      add_vec(4'd4, 4'd4, 4'd0, 1'b1);
      add_vec(4'd4, 4'd4, 4'd0, 1'b1);
      add_vec(4'd4, 4'd0, 4'd4, 1'b0);

      rst = 1'b0;
      btnC = 1'b0;
      drive_dir(4'd0);
      drive_blk(4'd0);

      repeat (3) @(negedge clk);
      check("reset btns", 8'(btns), 8'd0);
      check("reset blocked", 8'(blocked), 8'd0);
      check("reset player_color", 8'(player_color), 8'd1);
      check("reset btnClk", 8'(btnClk), 8'd0);
      rst = 1'b1;

      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check($sformatf("btnClk cycle %0d", i), 8'(btnClk), 8'(exp_clk[i]));
      end

      for (int i = 0; i < nv; i++) begin
         drive_dir(vecs[i].dir);
         drive_blk(vecs[i].blk);
         step_bnd();
         check($sformatf("vec%0d btns", i), 8'(btns), 8'(vecs[i].exp_btns));
         check($sformatf("vec%0d blocked", i), 8'(blocked), 8'(vecs[i].exp_blocked));
      end

      // Reset during REPEAT with D still held
      rst = 1'b0;
      #1;
      check("midreset btns", 8'(btns), 8'd0);
      check("midreset blocked", 8'(blocked), 8'd0);
      check("midreset btnClk", 8'(btnClk), 8'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      step_bnd();
      check("post-reset bnd1 btns", 8'(btns), 8'd0);
      step_bnd();
      check("post-reset bnd2 btns", 8'(btns), 8'd4);
      check("post-reset bnd2 blocked", 8'(blocked), 8'd0);
      drive_dir(4'd0);
      step_bnd();
      check("post-reset release1 btns", 8'(btns), 8'd0);
      step_bnd();
      check("post-reset release2 btns", 8'(btns), 8'd0);

      // Three-cycle glitch on L must not pass the debouncer
      btnL = 1'b1;
      repeat (3) @(negedge clk);
      btnL = 1'b0;
      step_bnd();
      check("glitch bnd1 btns", 8'(btns), 8'd0);
      step_bnd();
      check("glitch bnd2 btns", 8'(btns), 8'd0);
      check("glitch bnd2 blocked", 8'(blocked), 8'd0);

      // Block flag dropped only between boundaries has no effect
      drive_dir(4'd8);
      drive_blk(4'd8);
      step_bnd();
      check("pulse pre btns", 8'(btns), 8'd0);
      step_bnd();
      check("pulse blocked before", 8'(blocked), 8'd1);
      upBlock = 1'b0;
      @(negedge clk);
      upBlock = 1'b1;
      step_bnd();
      check("pulse btns", 8'(btns), 8'd0);
      check("pulse blocked", 8'(blocked), 8'd1);
      upBlock = 1'b0;
      step_bnd();
      check("unblock btns", 8'(btns), 8'd8);
      check("unblock blocked", 8'(blocked), 8'd0);
      drive_dir(4'd0);
      step_bnd();
      step_bnd();
      check("unblock release btns", 8'(btns), 8'd0);

      // 17 clean btnC presses, each held well past the debounce window
      for (int k = 1; k <= 17; k++) begin
         btnC = 1'b1;
         repeat (12) @(negedge clk);
         btnC = 1'b0;
         repeat (8) @(negedge clk);
         check($sformatf("color after press %0d", k), 8'(player_color), 8'((1 + k) % 16));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/btn_stepper.md
BTN_STEPPER -- requirements
Module: btn_stepper

Interface
REQ-001 Parameter DB_CYCLES, default 1000000; debounce stability window in clk cycles.
REQ-002 Parameter STEP_DIV, default 2500000; btnClk half-period in clk cycles.
REQ-003 Parameter REPEAT_DLY, default 8; btnClk periods a direction is held before auto-repeat.
REQ-004 Parameter COLOR_INIT, default 4'd1; player_color reset value.
REQ-005 clk  input  1  system clock; the design has one clock, and all registers are on its rising edge.
REQ-006 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-007 btnU, btnD, btnL, btnR, btnC  input  1 each  raw pushbuttons, asynchronous to clk.
REQ-008 upBlock, downBlock, leftBlock, rightBlock  input  1 each  OR of all object up/down/left/right disable flags (1 = direction blocked).
REQ-009 btnClk  output  1  step clock consumed by object blocks.
REQ-010 btns  output  4  one-hot step command: 8 = up, 4 = down, 2 = right, 1 = left, 0 = none.
REQ-011 player_color  output  4  current player colour.
REQ-012 blocked  output  1  high while the selected direction is held but gated by its block flag.

Function
REQ-013 Each raw button passes a 2-flop synchronizer before any other logic.
REQ-014 Debounce each button as follows.
- The debounced level changes only after the synchronized input differs from it for DB_CYCLES consecutive clk cycles.
- Any reversal within the window clears that button's counter.
REQ-015 btnClk toggles every STEP_DIV clk cycles, giving a period of 2*STEP_DIV cycles and 50% duty.
REQ-016 The "step boundary" is the clk cycle in which btnClk is driven 1->0.
REQ-017 btns and blocked update only at a step boundary, so btns is stable for a full period around each btnClk rising edge.
REQ-018 A valid direction d exists when exactly one of debounced U/D/R/L is pressed.
- Two or more directions pressed means no direction (d = none).
REQ-019 FSM states IDLE, HOLD and REPEAT are evaluated only at step boundaries.
REQ-020 IDLE behaviour:
- d valid and its block flag = 0: btns <= d, latch d, hold counter <= 0, next state HOLD.
- d valid and blocked: btns <= 0, blocked <= 1, stay IDLE.
- Otherwise: btns <= 0, blocked <= 0.
REQ-021 HOLD behaviour:
- btns <= 0.
- d equals the latched direction: increment the hold counter; on reaching REPEAT_DLY-1, go to REPEAT.
- Otherwise go to IDLE; a new direction is not issued at this boundary.
REQ-022 REPEAT behaviour:
- Same d, not blocked: btns <= d, blocked <= 0.
- Same d, blocked: btns <= 0, blocked <= 1, stay REPEAT.
- d changed or released: btns <= 0, blocked <= 0, go to IDLE.
REQ-023 Block flags are sampled at the step boundary only; block changes between boundaries have no effect.
REQ-024 A debounced btnC rising edge increments player_color by 1, modulo 16 (15 -> 0), in the following clk cycle.
- This is independent of step boundaries and of the FSM.
REQ-025 btnC held produces exactly one increment; btnC release produces none.
REQ-026 Counter widths:
- Debounce counters are sized by $clog2(DB_CYCLES+1).
- The divider counter is sized by $clog2(STEP_DIV).
- The hold counter is sized by $clog2(REPEAT_DLY+1).
- No counter wraps in normal operation.

Reset
REQ-027 While rst = 0, the following hold immediately without a clock:
- btnClk = 0, btns = 0, blocked = 0, player_color = COLOR_INIT, FSM = IDLE.
- All counters, synchronizers and debounced levels = 0.
REQ-028 Reset asserted mid-step discards any in-progress debounce, hold count or repeat.
- After release, the divider restarts from 0, and the first btnClk rise occurs STEP_DIV cycles later.
REQ-029 A button held through reset release must re-debounce for DB_CYCLES before any command is issued.

Verification
Bench parameters: DB_CYCLES=4, STEP_DIV=2, REPEAT_DLY=3.
REQ-030 Reset/clock: hold rst=0 for 3 cycles, then release.
- During reset: btns=0, player_color=1, btnClk=0.
- After release: btnClk toggles every 2 clk cycles.
REQ-031 Single step plus auto-repeat: press btnR, hold for 40 cycles.
- btns=2 for the first full period after debounce.
- Then 0 for 3 periods.
- Then 2 on every following period.
- Release: btns=0 at the next boundary.
REQ-032 Block gating: hold btnU with upBlock=1.
- btns stays 0 and blocked=1.
- Drop upBlock: btns=8 at the next boundary, blocked=0.
REQ-033 Debounce and conflicts:
- Glitch btnL for 3 cycles: no command.
- Hold btnU and btnD together: btns stays 0 and FSM stays IDLE.
REQ-034 Colour: 17 clean btnC presses from reset -> player_color ends at 2, having wrapped 15 -> 0.
REQ-035 Reset mid-operation: assert rst during REPEAT with btns=4.
- btns=0 immediately.
- After release with btnD still held, no command until debounce plus a full REQ-020 cycle completes.
